// File: rtl/wb_pkg.sv
// Shared Wishbone constants and bridge state encoding
// for the video-RAM bridge slice.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        BURST
    } bridge_state_t;

endpackage

// File: rtl/wb_ram_bridge_if.sv
// Wishbone B4 bus bundle between a master and the
// video-RAM bridge slave.
interface wb_ram_bridge_if #(
    parameter int DATA_WIDTH = 32
);

    logic                    wb_cyc;
    logic                    wb_stb;
    logic                    wb_we;
    logic [31:0]             wb_adr;
    logic [DATA_WIDTH-1:0]   wb_dat_ms;
    logic [DATA_WIDTH/8-1:0] wb_sel;
    logic [2:0]              wb_cti;
    logic [1:0]              wb_bte;
    logic [DATA_WIDTH-1:0]   wb_dat_sm;
    logic                    wb_ack;

    modport master (
        output wb_cyc,
        output wb_stb,
        output wb_we,
        output wb_adr,
        output wb_dat_ms,
        output wb_sel,
        output wb_cti,
        output wb_bte,
        input  wb_dat_sm,
        input  wb_ack
    );

    modport slave (
        input  wb_cyc,
        input  wb_stb,
        input  wb_we,
        input  wb_adr,
        input  wb_dat_ms,
        input  wb_sel,
        input  wb_cti,
        input  wb_bte,
        output wb_dat_sm,
        output wb_ack
    );

endinterface

// File: rtl/wb_burst_addr_inc.sv
// Next-beat word address for Wishbone incrementing
// bursts: linear, or wrapping inside a 4/8/16 block.
module wb_burst_addr_inc
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_bte,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_plus1;

    // Bits allowed to change; the rest of the address is held.
    always_comb begin
        w_mask = '1;
        unique case (i_bte)
            BTE_LINEAR: w_mask = '1;
            BTE_WRAP4:  w_mask = ADDR_WIDTH'(3);
            BTE_WRAP8:  w_mask = ADDR_WIDTH'(7);
            BTE_WRAP16: w_mask = ADDR_WIDTH'(15);
        endcase
    end

    assign w_plus1 = i_addr + ADDR_WIDTH'(1);
    assign o_addr  = (i_addr & ~w_mask) | (w_plus1 & w_mask);

endmodule

// File: rtl/wb_ram_bridge.sv
// Wishbone B4 slave driving a synchronous-read byte-enabled
// RAM; read bursts prefetch the next word one cycle ahead.
module wb_ram_bridge
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    wb_ram_bridge_if.slave          wb,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    output logic                    ram_we,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    bridge_state_t         r_state;
    logic                  r_ack_q;
    logic [ADDR_WIDTH-1:0] r_beat_addr;

    bridge_state_t         w_state_nx;
    logic                  w_ack_nx;
    logic [ADDR_WIDTH-1:0] w_beat_nx;
    logic                  w_req;
    logic                  w_ack;
    logic                  w_we_body;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [ADDR_WIDTH-1:0] w_inc_addr;
    logic                  w_unused;

    assign w_req    = wb.wb_cyc & wb.wb_stb;
    assign w_ack    = r_ack_q & w_req;
    assign w_word   = wb.wb_adr[ADDR_WIDTH+1:2];
    assign w_unused = &{1'b0, wb.wb_adr[31:ADDR_WIDTH+2],
                        wb.wb_adr[1:0]};

    assign wb.wb_ack    = w_ack;
    assign wb.wb_dat_sm = ram_rdata;
    assign ram_wdata    = wb.wb_dat_ms;
    assign ram_be       = wb.wb_sel;

    wb_burst_addr_inc #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_inc (
        .i_addr(r_beat_addr),
        .i_bte (wb.wb_bte),
        .o_addr(w_inc_addr)
    );

    // State, registered ack and burst beat address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ack_q     <= 1'b0;
            r_beat_addr <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_ack_q     <= w_ack_nx;
            r_beat_addr <= w_beat_nx;
        end
    end

    // Transfer sequencing: classic single ack or burst.
    always_comb begin
        w_state_nx = r_state;
        w_ack_nx   = r_ack_q;
        w_beat_nx  = r_beat_addr;
        unique case (r_state)
            IDLE: begin
                w_ack_nx = w_req;
                if (w_req) begin
                    w_beat_nx  = w_word;
                    w_state_nx = (wb.wb_cti == CTI_INCR)
                               ? BURST : ACK;
                end
            end
            ACK: begin
                w_ack_nx   = 1'b0;
                w_state_nx = IDLE;
            end
            BURST: begin
                w_ack_nx = w_req;
                if (w_req) begin
                    w_beat_nx = ram_addr;
                end
                if (!wb.wb_cyc ||
                    (w_ack && wb.wb_cti == CTI_EOB)) begin
                    w_ack_nx   = 1'b0;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_ack_nx   = 1'b0;
                w_state_nx = IDLE;
            end
        endcase
    end

    // RAM strobes; read bursts run one word ahead on ack.
    always_comb begin
        ram_addr  = w_word;
        w_we_body = 1'b0;
        unique case (r_state)
            IDLE: w_we_body = w_req & wb.wb_we;
            ACK:  w_we_body = 1'b0;
            BURST: begin
                if (wb.wb_we) begin
                    w_we_body = w_req;
                end else begin
                    ram_addr = w_ack ? w_inc_addr : r_beat_addr;
                end
            end
            default: w_we_body = 1'b0;
        endcase
        ram_we = w_we_body & rst_n;
    end

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Randomised scoreboard bench for wb_ram_bridge with a
// behavioural RAM and a word-array reference model.
module tb_wb_ram_bridge;
    import wb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_ram_bridge_if #(.DATA_WIDTH(DW)) wb ();

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [3:0]    ram_be;
    logic          ram_we;

    wb_ram_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb       (wb),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_be   (ram_be),
        .ram_we   (ram_we),
        .ram_rdata(ram_rdata)
    );

    // Byte-enabled single-port RAM, registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end else begin
            ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        bit          rd;
        logic [31:0] d;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [0:(1<<AW)-1];
    int          n_vec = 0;
    int          n_err = 0;
    int          we_cnt = 0;

    always @(negedge clk) if (ram_we) we_cnt++;

    // Monitor: every ack consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && wb.wb_ack) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ack: got ack with dat %0h, required no ack", wb.wb_dat_sm);
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.rd && wb.wb_dat_sm !== mon_e.d) begin
                    n_err++;
                    $display("FAIL rd_data: got %0h required %0h", wb.wb_dat_sm, mon_e.d);
                end else if (!mon_e.rd && wb.wb_we !== 1'b1) begin
                    n_err++;
                    $display("FAIL ack_dir: got we %0b required 1", wb.wb_we);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    function automatic void ref_write(int w, logic [31:0] d, logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic int beat_word(int s, int i, logic [1:0] bte);
        int len;
        if (bte == BTE_LINEAR) return (s + i) % (1 << AW);
        len = 2 << bte;
        return (s - s % len) + (s % len + i) % len;
    endfunction

    task automatic bus_idle();
        wb.wb_cyc = 1'b0;
        wb.wb_stb = 1'b0;
        wb.wb_we  = 1'b0;
        wb.wb_cti = CTI_CLASSIC;
    endtask

    task automatic classic(bit we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel);
        int w, k, base;
        bit got;
        w = int'(adr[AW+1:2]);
        if (we) begin
            ref_write(w, dat, sel);
            sbq.push_back('{rd: 1'b0, d: 32'h0});
        end else begin
            sbq.push_back('{rd: 1'b1, d: ref_mem[w]});
        end
        @(posedge clk); #1;
        wb.wb_cyc    = 1'b1;
        wb.wb_stb    = 1'b1;
        wb.wb_we     = we;
        wb.wb_adr    = adr;
        wb.wb_dat_ms = dat;
        wb.wb_sel    = sel;
        wb.wb_bte    = 2'($urandom);
        wb.wb_cti    = ($urandom_range(0, 1) == 1) ? CTI_CLASSIC : 3'($urandom_range(3, 7));
        base = we_cnt;
        k = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            got = wb.wb_ack;
        end
        chk("classic_ack_latency", k, 2);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        if (we) chk("classic_we_pulses", we_cnt - base, 1);
    endtask

    task automatic burst(bit we, int start, int len, logic [1:0] bte, int stall_at, int rst_at);
        int          words[$];
        logic [31:0] wd[$];
        int          beat, cyc_cnt, stall_left, nwr;
        bit          prev_req, exp_ack, stalled, acked;
        for (int i = 0; i < len; i++) begin
            words.push_back(beat_word(start, i, bte));
            wd.push_back($urandom);
        end
        nwr = (rst_at >= 0) ? rst_at : len;
        for (int i = 0; i < len; i++) begin
            if (we) begin
                if (i < nwr) begin
                    ref_write(words[i], wd[i], 4'hF);
                    sbq.push_back('{rd: 1'b0, d: 32'h0});
                end
            end else begin
                sbq.push_back('{rd: 1'b1, d: ref_mem[words[i]]});
            end
        end
        @(posedge clk); #1;
        wb.wb_cyc    = 1'b1;
        wb.wb_stb    = 1'b1;
        wb.wb_we     = we;
        wb.wb_adr    = 32'(words[0]) << 2;
        wb.wb_dat_ms = wd[0];
        wb.wb_sel    = 4'hF;
        wb.wb_bte    = bte;
        wb.wb_cti    = (len == 1) ? CTI_EOB : CTI_INCR;
        beat = 0;
        cyc_cnt = 0;
        stall_left = 0;
        prev_req = 1'b0;
        stalled = 1'b0;
        while (beat < len && cyc_cnt < 100) begin
            @(negedge clk);
            cyc_cnt++;
            exp_ack  = prev_req && wb.wb_stb;
            prev_req = wb.wb_stb;
            acked    = wb.wb_ack;
            chk("burst_ack", acked, exp_ack);
            if (acked) beat++;
            @(posedge clk); #1;
            if (beat == len) break;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) wb.wb_stb = 1'b1;
            end else if (acked && beat == stall_at && !stalled) begin
                wb.wb_stb  = 1'b0;
                stall_left = 2;
                stalled    = 1'b1;
            end
            wb.wb_adr    = 32'(words[beat]) << 2;
            wb.wb_dat_ms = wd[beat];
            wb.wb_cti    = (beat == len - 1) ? CTI_EOB : CTI_INCR;
            if (beat == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_burst_ack", wb.wb_ack, 0);
                chk("rst_mid_burst_we", ram_we, 0);
                bus_idle();
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
        end
        chk("burst_beats", beat, len);
        bus_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] adr;
        int          op, len, st, sa;
        logic [1:0]  bte;

        wb.wb_cyc    = 1'b1;
        wb.wb_stb    = 1'b1;
        wb.wb_we     = 1'b1;
        wb.wb_adr    = 32'h10;
        wb.wb_dat_ms = 32'h0;
        wb.wb_sel    = 4'hF;
        wb.wb_cti    = CTI_CLASSIC;
        wb.wb_bte    = BTE_LINEAR;
        #12;
        chk("reset_ack", wb.wb_ack, 0);
        chk("reset_we", ram_we, 0);
        bus_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int w = 0; w < 64; w++)
            classic(1'b1, 32'(w) << 2, 32'(w), 4'hF);

        classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        classic(1'b0, 32'h10, 32'h0, 4'hF);
        classic(1'b1, 32'h10, 32'h11223344, 4'hF);
        classic(1'b1, 32'h10, 32'h0000AB00, 4'b0010);
        classic(1'b0, 32'h10, 32'h0, 4'hF);
        classic(1'b1, 32'h10, 32'h4, 4'hF);

        burst(1'b0, 0, 8, BTE_LINEAR, -1, -1);
        burst(1'b0, 6, 4, BTE_WRAP4, -1, -1);
        burst(1'b0, 5, 8, BTE_WRAP8, -1, -1);
        burst(1'b0, 16, 8, BTE_LINEAR, 3, -1);

        classic(1'b1, 32'hABCD_E0A0, 32'h5A5A_0F0F, 4'hF);
        classic(1'b0, 32'h1234_50A3, 32'h0, 4'hF);

        burst(1'b1, 40, 6, BTE_LINEAR, -1, 3);
        for (int w = 40; w < 44; w++)
            classic(1'b0, 32'(w) << 2, 32'h0, 4'hF);

        for (int n = 0; n < 40; n++) begin
            op  = $urandom_range(0, 3);
            bte = 2'($urandom);
            len = $urandom_range(1, 8);
            sa  = (len > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
            st  = (bte == BTE_LINEAR) ? $urandom_range(0, 63 - len) : $urandom_range(0, 63);
            adr = $urandom;
            adr[11:2] = 10'($urandom_range(0, 63));
            case (op)
                0: classic(1'b1, adr, $urandom, 4'($urandom_range(1, 15)));
                1: classic(1'b0, adr, 32'h0, 4'hF);
                2: burst(1'b0, st, len, bte, sa, -1);
                default: burst(1'b1, st, len, bte, sa, -1);
            endcase
        end

        for (int w = 0; w < 64; w += 8)
            burst(1'b0, w, 8, BTE_LINEAR, -1, -1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
